// File: rtl/rst_seq_rx.sv
// Purpose : reset receiver/sequencer; synchronises Rst release, then releases core and peripheral domains in order.
// Latency : RstCore_n rises SYNC_STAGES+CORE_DLY edges after release, RstPeriph_n/Ready PERIPH_DLY edges later.
// Backpr. : SwRstReq is a level held until SwRstAck; requests outside RUN are ignored and not counted.
//
// Ports:
//   Clk          system clock, rising edge
//   Rst          asynchronous active-high system reset
//   SwRstReq     software reset request (level)
//   SwRstAck     one-cycle acknowledge of an accepted request
//   RstCore_n    core domain reset, active low
//   RstPeriph_n  peripheral domain reset, active low
//   Ready        both domains out of reset
//   RstCount     accepted software resets, saturating
module rst_seq_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int CORE_DLY    = 16,
    parameter int PERIPH_DLY  = 8,
    parameter int CNT_W       = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             SwRstReq,
    output logic             SwRstAck,
    output logic             RstCore_n,
    output logic             RstPeriph_n,
    output logic             Ready,
    output logic [CNT_W-1:0] RstCount
);

    typedef enum logic [2:0] {
        HOLD        = 3'd0,
        CORE_WAIT   = 3'd1,
        PERIPH_WAIT = 3'd2,
        RUN         = 3'd3,
        SW_RST      = 3'd4
    } state_t;

    localparam int MAX_DLY = (CORE_DLY > PERIPH_DLY) ? CORE_DLY : PERIPH_DLY;
    localparam int DLY_W   = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;

    // Wait states exit when the counter reads zero, so a delay of N edges loads N-1.
    localparam logic [DLY_W-1:0] CORE_LD   = DLY_W'(CORE_DLY - 1);
    localparam logic [DLY_W-1:0] PERIPH_LD = DLY_W'(PERIPH_DLY - 1);

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [DLY_W-1:0]       r_dly;
    logic                   r_core_n;
    logic                   r_periph_n;
    logic                   r_ack;
    logic [CNT_W-1:0]       r_cnt;

    state_t                 w_state_nxt;
    logic [DLY_W-1:0]       w_dly_nxt;
    logic                   w_core_n_nxt;
    logic                   w_periph_n_nxt;
    logic                   w_ack_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_sync_done;

    // The last stage turns 1 on this edge when the one before it is already 1;
    // leaving HOLD on that same edge puts synchronised release at E(SYNC_STAGES).
    assign w_sync_done = r_sync[SYNC_STAGES-2];

    // State register: every output is a flop, cleared asynchronously by Rst.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state    <= HOLD;
            r_sync     <= '0;
            r_dly      <= '0;
            r_core_n   <= 1'b0;
            r_periph_n <= 1'b0;
            r_ack      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            // Keeps shifting ones; after release it stays all-ones, so a
            // software reset never re-runs the synchroniser.
            r_sync     <= {r_sync[SYNC_STAGES-2:0], 1'b1};
            r_dly      <= w_dly_nxt;
            r_core_n   <= w_core_n_nxt;
            r_periph_n <= w_periph_n_nxt;
            r_ack      <= w_ack_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    // Next-state and shared delay counter.
    always_comb begin
        w_state_nxt = r_state;
        w_dly_nxt   = r_dly;
        case (r_state)
            HOLD: begin
                if (w_sync_done) begin
                    w_state_nxt = CORE_WAIT;
                    w_dly_nxt   = CORE_LD;
                end
            end
            CORE_WAIT: begin
                if (r_dly == '0) begin
                    w_state_nxt = PERIPH_WAIT;
                    w_dly_nxt   = PERIPH_LD;
                end else begin
                    w_dly_nxt = r_dly - DLY_W'(1);
                end
            end
            PERIPH_WAIT: begin
                if (r_dly == '0) begin
                    w_state_nxt = RUN;
                end else begin
                    w_dly_nxt = r_dly - DLY_W'(1);
                end
            end
            RUN: begin
                if (SwRstReq) begin
                    w_state_nxt = SW_RST;
                end
            end
            SW_RST: begin
                w_state_nxt = CORE_WAIT;
                w_dly_nxt   = CORE_LD;
            end
            default: begin
                w_state_nxt = HOLD;
                w_dly_nxt   = '0;
            end
        endcase
    end

    // Output decode from the next state, so registered outputs change on the
    // same edge as the state. Core is released in both PERIPH_WAIT and RUN,
    // peripheral only in RUN, which makes the release order structural.
    always_comb begin
        w_core_n_nxt   = (w_state_nxt == PERIPH_WAIT) || (w_state_nxt == RUN);
        w_periph_n_nxt = (w_state_nxt == RUN);
        w_ack_nxt      = (r_state == RUN) && (w_state_nxt == SW_RST);
        w_cnt_nxt      = r_cnt;
        if (w_ack_nxt && (r_cnt != {CNT_W{1'b1}})) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    assign SwRstAck    = r_ack;
    assign RstCore_n   = r_core_n;
    assign RstPeriph_n = r_periph_n;
    // Ready is by definition identical to the peripheral release flop.
    assign Ready       = r_periph_n;
    assign RstCount    = r_cnt;

endmodule

// File: tb/tb_rst_seq_rx.sv
module tb_rst_seq_rx;

    logic       Clk;
    logic       Rst;
    logic       SwRstReq;
    logic       SwRstAck;
    logic       RstCore_n;
    logic       RstPeriph_n;
    logic       Ready;
    logic [7:0] RstCount;

    logic       sat_req;
    logic       sat_ack;
    logic       sat_core_n;
    logic       sat_periph_n;
    logic       sat_ready;
    logic [1:0] sat_cnt;

    int n_chk;
    int n_err;

    rst_seq_rx #(.SYNC_STAGES(2), .CORE_DLY(16), .PERIPH_DLY(8), .CNT_W(8)) dut (
        .Clk(Clk), .Rst(Rst), .SwRstReq(SwRstReq), .SwRstAck(SwRstAck),
        .RstCore_n(RstCore_n), .RstPeriph_n(RstPeriph_n), .Ready(Ready),
        .RstCount(RstCount)
    );

    rst_seq_rx #(.SYNC_STAGES(2), .CORE_DLY(16), .PERIPH_DLY(8), .CNT_W(2)) dut_sat (
        .Clk(Clk), .Rst(Rst), .SwRstReq(sat_req), .SwRstAck(sat_ack),
        .RstCore_n(sat_core_n), .RstPeriph_n(sat_periph_n), .Ready(sat_ready),
        .RstCount(sat_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       rst;
        logic       req;
        int         edges;
        logic       core_n;
        logic       periph_n;
        logic       ready;
        logic       ack;
        logic [7:0] cnt;
        string      name;
    } vec_t;

    vec_t vt[21];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Ordering invariant on both instances, evaluated after every edge.
    task automatic check_order();
        n_chk++;
        if ((RstPeriph_n === 1'b1 && RstCore_n !== 1'b1) || (Ready !== RstPeriph_n) ||
            (sat_periph_n === 1'b1 && sat_core_n !== 1'b1) || (sat_ready !== sat_periph_n)) begin
            n_err++;
            $display("FAIL order: core=%b periph=%b ready=%b sat core=%b periph=%b ready=%b required periph->core and ready==periph at %0t",
                     RstCore_n, RstPeriph_n, Ready, sat_core_n, sat_periph_n, sat_ready, $time);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge Clk);
            #1;
            check_order();
        end
    endtask

    task automatic chk_main(input string nm, input logic c, input logic p, input logic r,
                            input logic a, input logic [7:0] cnt);
        chk({nm, ".core_n"},   {7'd0, RstCore_n},   {7'd0, c});
        chk({nm, ".periph_n"}, {7'd0, RstPeriph_n}, {7'd0, p});
        chk({nm, ".ready"},    {7'd0, Ready},       {7'd0, r});
        chk({nm, ".ack"},      {7'd0, SwRstAck},    {7'd0, a});
        chk({nm, ".count"},    RstCount,            cnt);
    endtask

    initial begin
        int waited;
        logic [7:0] exp_sat;

        n_chk    = 0;
        n_err    = 0;
        Rst      = 1'b0;
        SwRstReq = 1'b0;
        sat_req  = 1'b0;

        // Reset assertion must clear outputs with no clock edge.
        #2 Rst = 1'b1;
        #1;
        chk_main("async_por", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        //             rst   req  edges core periph ready ack  cnt
        vt[0]  = '{1'b1, 1'b0, 10, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "por_hold"};
        vt[1]  = '{1'b0, 1'b0,  2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "por_E2"};
        vt[2]  = '{1'b0, 1'b0, 15, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "por_E17"};
        vt[3]  = '{1'b0, 1'b0,  1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "por_E18_core"};
        vt[4]  = '{1'b0, 1'b0,  7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "por_E25"};
        vt[5]  = '{1'b0, 1'b0,  1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, "por_E26_ready"};
        vt[6]  = '{1'b0, 1'b0,  5, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, "run_idle"};
        vt[7]  = '{1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, "sw1_S0_ack"};
        vt[8]  = '{1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, "sw1_S1"};
        vt[9]  = '{1'b0, 1'b0, 15, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, "sw1_S16"};
        vt[10] = '{1'b0, 1'b0,  1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, "sw1_S17_core"};
        vt[11] = '{1'b0, 1'b0,  7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, "sw1_S24"};
        vt[12] = '{1'b0, 1'b0,  1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, "sw1_S25_ready"};
        vt[13] = '{1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, "sw2_S0_ack"};
        vt[14] = '{1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, "sw2_S1"};
        vt[15] = '{1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, "sw2_S17_core"};
        vt[16] = '{1'b0, 1'b1,  7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, "ign_periph_wait"};
        vt[17] = '{1'b0, 1'b1,  1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd2, "ign_S25_run"};
        vt[18] = '{1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3, "ign_accept"};
        vt[19] = '{1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, "ign_S1"};
        vt[20] = '{1'b0, 1'b0, 24, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3, "sw3_S25_ready"};

        for (int i = 0; i < 21; i++) begin
            Rst      = vt[i].rst;
            SwRstReq = vt[i].req;
            step(vt[i].edges);
            chk_main(vt[i].name, vt[i].core_n, vt[i].periph_n, vt[i].ready,
                     vt[i].ack, vt[i].cnt);
        end

        // Short Rst pulse from RUN: outputs drop between edges.
        Rst = 1'b1;
        #1;
        chk_main("abort_run_async", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        #2 Rst = 1'b0;
        step(26);
        chk_main("abort_run_E26", 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);

        // Software reset, then abort while in CORE_WAIT.
        SwRstReq = 1'b1;
        step(1);
        chk_main("cw_S0_ack", 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
        SwRstReq = 1'b0;
        step(5);
        chk_main("cw_S5", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
        Rst = 1'b1;
        #1;
        chk_main("abort_cw_async", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        #2 Rst = 1'b0;
        step(17);
        chk_main("abort_cw_E17", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1);
        chk_main("abort_cw_E18", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step(8);
        chk_main("abort_cw_E26", 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);

        // Saturating counter on the 2-bit instance: 1,2,3,3,3 and every request acks.
        for (int i = 0; i < 5; i++) begin
            waited = 0;
            while (sat_ready !== 1'b1 && waited < 60) begin
                step(1);
                waited++;
            end
            chk($sformatf("sat%0d.ready_wait", i), {7'd0, sat_ready}, 8'd1);
            sat_req = 1'b1;
            step(1);
            exp_sat = (i < 3) ? 8'(i + 1) : 8'd3;
            chk($sformatf("sat%0d.ack", i),    {7'd0, sat_ack},    8'd1);
            chk($sformatf("sat%0d.core_n", i), {7'd0, sat_core_n}, 8'd0);
            chk($sformatf("sat%0d.count", i),  {6'd0, sat_cnt},    exp_sat);
            sat_req = 1'b0;
            step(1);
            chk($sformatf("sat%0d.ack_drop", i), {7'd0, sat_ack}, 8'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rst_seq_rx.md
# rst_seq_rx

Reset receiver and sequencer for the I2C functional-model system. It takes the system reset driven by the testbench reset generator and synchronises its release to `Clk`. It then releases two downstream reset domains in order, core first and peripheral (I2C master/slave models) second. It also serves a software reset request/acknowledge handshake and counts software resets.

## Interface
Parameters:
- SYNC_STAGES, 2, synchroniser depth for `Rst` deassertion (legal ≥ 2)
- CORE_DLY, 16, cycles from synchronised release to `RstCore_n` release (legal ≥ 1)
- PERIPH_DLY, 8, cycles from `RstCore_n` release to `RstPeriph_n` release (legal ≥ 1)
- CNT_W, 8, width of the software-reset counter

Ports:
- Clk  input  1  system clock, all logic on rising edge
- Rst  input  1  system reset; one clock, reset is asynchronous and active-high
- SwRstReq  input  1  software reset request, level
- SwRstAck  output  1  one-cycle acknowledge of an accepted `SwRstReq`
- RstCore_n  output  1  core domain reset, active low
- RstPeriph_n  output  1  peripheral domain reset, active low
- Ready  output  1  high when both domains are out of reset (state RUN)
- RstCount  output  CNT_W  number of accepted software resets, saturating

## Operation
- States: HOLD, CORE_WAIT, PERIPH_WAIT, RUN, SW_RST. One down-counter is shared by the wait states.
- Assertion of `Rst` is asynchronous and forces the following immediately, with no clock required:
  - state = HOLD, synchroniser chain = 0, counter cleared
  - `RstCore_n`=0, `RstPeriph_n`=0, `Ready`=0, `SwRstAck`=0, `RstCount`=0
- HOLD: the synchroniser shifts in 1 each edge while `Rst`=0. When its last stage is 1, go to CORE_WAIT and load the counter.
- CORE_WAIT: count CORE_DLY edges, then set `RstCore_n`=1 and go to PERIPH_WAIT.
- PERIPH_WAIT: count PERIPH_DLY edges, then set `RstPeriph_n`=1 and `Ready`=1 on the same edge, and go to RUN.
- RUN: if `SwRstReq`=1 is sampled, go to SW_RST on that edge. On the same edge:
  - drive `RstCore_n`=0, `RstPeriph_n`=0, `Ready`=0
  - pulse `SwRstAck`=1 for exactly one cycle
  - increment `RstCount`, saturating at all-ones
- SW_RST: lasts one cycle, then go to CORE_WAIT with the counter loaded. The synchroniser is not re-run; it stays at all-ones.
- `SwRstReq` is ignored outside RUN: no ack, no count. The requester holds it until `SwRstAck` and drops it the next cycle. If it is still high when RUN is re-entered, another sequence starts.
- Outputs are registered and glitch-free. The two reset outputs never release in the wrong order: `RstPeriph_n`=1 implies `RstCore_n`=1.

## Timing
- Reset values: `RstCore_n`=0, `RstPeriph_n`=0, `Ready`=0, `SwRstAck`=0, `RstCount`=0.
- Edge E1 is the first rising `Clk` edge at which `Rst`=0 is sampled.
- Synchronised release occurs at edge E(SYNC_STAGES).
- `RstCore_n` rises at edge E(SYNC_STAGES+CORE_DLY). With defaults this is E18.
- `RstPeriph_n` and `Ready` rise at edge E(SYNC_STAGES+CORE_DLY+PERIPH_DLY). With defaults this is E26.
- Software reset: let edge S0 sample `SwRstReq`=1 in RUN.
  - Both resets fall and `SwRstAck` rises at S0. `SwRstAck` falls at S1.
  - `RstCore_n` rises at S(1+CORE_DLY).
  - `RstPeriph_n` and `Ready` rise at S(1+CORE_DLY+PERIPH_DLY).
- `Rst` asserted mid-sequence (any state, including SW_RST) aborts the sequence immediately. The full sequence restarts from the new E1.
- `Rst` pulses shorter than one clock period still produce a full sequence, because assertion is asynchronous.
- Counter saturation: at all-ones, further accepted requests still ack and reset the domains, but `RstCount` holds.

## Test plan
- Power-on: `Rst`=1 for 100 ns, then 0 → `RstCore_n` rises at E18, `RstPeriph_n`/`Ready` rise at E26, `RstCount`=0.
- Software reset: `SwRstReq` high in RUN until ack → one-cycle `SwRstAck`, both resets low at S0, `RstCore_n` rises at S17, `Ready` rises at S25, `RstCount`=1.
- Ignored request: `SwRstReq` held high during PERIPH_WAIT → no ack and no count before RUN. The request is accepted on the first RUN edge, giving `RstCount`=1.
- Mid-sequence abort: `Rst` pulsed 3 ns while in CORE_WAIT → outputs go low immediately and asynchronously; the sequence restarts with `RstCore_n` rising 18 edges after release.
- Saturation: CNT_W=2, 5 software resets → `RstCount` reads 1, 2, 3, 3, 3, and every request still acks.
- Ordering check: assertion on every cycle that `RstPeriph_n`=1 implies `RstCore_n`=1, and that `Ready` equals `RstPeriph_n` in all scenarios.
